instr_trace_buffer: RTL and testbench

- Retirement-trace capture stage directly downstream of the single-cycle MIPS core.
- Samples the core's `pc`/`ins` outputs every clock and stores selected (pc, ins, timestamp) records in a FIFO.
- A host or debug port drains the FIFO through a valid/ready handshake.
- Two modes: full trace, or compressed trace that keeps only control-flow discontinuities.

---
 rtl/instr_trace_buffer_if.sv | 14 +
 rtl/instr_trace_buffer.sv | 84 ++++++++
 tb/tb_instr_trace_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/instr_trace_buffer_if.sv
// Drain-side handshake of the instruction trace buffer.
// The master presents head records; the slave accepts them with rd_ready.
interface instr_trace_buffer_if #(
  parameter int STAMP_W = 16
);
  logic               rd_valid;
  logic               rd_ready;
  logic [31:0]        rd_pc;
  logic [31:0]        rd_ins;
  logic [STAMP_W-1:0] rd_stamp;

  modport master (output rd_valid, rd_pc, rd_ins, rd_stamp, input rd_ready);
  modport slave  (input rd_valid, rd_pc, rd_ins, rd_stamp, output rd_ready);
endinterface

// File: rtl/instr_trace_buffer.sv
// Retirement-trace capture FIFO: samples pc/ins each clock, optionally keeping only
// control-flow discontinuities, and drains through a show-ahead valid/ready port.
module instr_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                   clk,
  input  logic                   PcReSet,
  input  logic                   trace_en,
  input  logic                   mode,
  input  logic [31:0]            pc,
  input  logic [31:0]            ins,
  instr_trace_buffer_if.master   rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]        mem_pc    [DEPTH];
  logic [31:0]        mem_ins   [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [STAMP_W-1:0] stamp;
  logic [31:0]        prev_pc;
  logic               prev_valid;
  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd.rd_ready & ~empty;

  // Sequential flow means pc == prev_pc + 4 (mod 2^32); anything else is a discontinuity.
  assign capture = trace_en & (~mode | ~prev_valid | (pc != prev_pc + 32'd4));
  assign push    = capture & (~full | pop);
  assign drop    = capture & ~push;

  always_ff @(posedge clk or negedge PcReSet) begin
    if (!PcReSet) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      stamp      <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else begin
      stamp      <= stamp + STAMP_W'(1);
      prev_valid <= trace_en;
      if (trace_en)
        prev_pc <= pc;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // When full with a pop, wr_ptr == rd_ptr: the head is read before the slot is reused.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_ins[wr_ptr]   <= ins;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  assign rd.rd_valid = ~empty;
  assign rd.rd_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign rd.rd_ins   = empty ? '0 : mem_ins[rd_ptr];
  assign rd.rd_stamp = empty ? '0 : mem_stamp[rd_ptr];
endmodule

// File: tb/tb_instr_trace_buffer.sv
// Bench for instr_trace_buffer: directed capture vectors feed a scoreboard queue,
// and a negedge monitor checks every popped record against it.
module tb_instr_trace_buffer;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        ins;
    logic [STAMP_W-1:0] stamp;
  } rec_t;

  logic               clk      = 1'b0;
  logic               PcReSet  = 1'b0;
  logic               trace_en = 1'b0;
  logic               mode     = 1'b0;
  logic [31:0]        pc       = '0;
  logic [31:0]        ins      = '0;
  logic [4:0]         count;
  logic               full;
  logic               empty;
  logic [15:0]        drop_cnt;
  logic [STAMP_W-1:0] m_stamp;
  rec_t               sb [$];
  rec_t               exp_rec;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  instr_trace_buffer_if #(.STAMP_W(STAMP_W)) rd_if ();

  instr_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk      (clk),
    .PcReSet  (PcReSet),
    .trace_en (trace_en),
    .mode     (mode),
    .pc       (pc),
    .ins      (ins),
    .rd       (rd_if),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle stamp: zero in reset, +1 every clock afterwards.
  always @(posedge clk or negedge PcReSet) begin
    if (!PcReSet) m_stamp <= '0;
    else          m_stamp <= m_stamp + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs; optionally record that this cycle must be stored.
  task automatic step(input logic te, input logic md, input logic [31:0] p,
                      input logic [31:0] i, input logic rdy, input logic store);
    rec_t r;
    trace_en       = te;
    mode           = md;
    pc             = p;
    ins            = i;
    rd_if.rd_ready = rdy;
    if (store) begin
      r.pc    = p;
      r.ins   = i;
      r.stamp = m_stamp;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (PcReSet && rd_if.rd_valid && rd_if.rd_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%08h, required no entry", rd_if.rd_pc);
      end else begin
        exp_rec = sb.pop_front();
        chk("pop_pc",    rd_if.rd_pc,          exp_rec.pc);
        chk("pop_ins",   rd_if.rd_ins,         exp_rec.ins);
        chk("pop_stamp", 32'(rd_if.rd_stamp),  32'(exp_rec.stamp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rd_if.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count),          32'd0);
    chk("rst_empty", 32'(empty),          32'd1);
    chk("rst_full",  32'(full),           32'd0);
    chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("rst_pc",    rd_if.rd_pc,         32'd0);
    chk("rst_drop",  32'(drop_cnt),       32'd0);
    PcReSet = 1'b1;

    // Full trace
    step(1, 0, 32'h0000_3000, 32'h2008_0001, 0, 1);
    step(1, 0, 32'h0000_3004, 32'h2009_0002, 0, 1);
    step(1, 0, 32'h0000_3008, 32'h0109_5020, 0, 1);
    chk("t1_count", 32'(count),          32'd3);
    chk("t1_valid", 32'(rd_if.rd_valid), 32'd1);
    chk("t1_pc",    rd_if.rd_pc,         32'h0000_3000);
    chk("t1_ins",   rd_if.rd_ins,        32'h2008_0001);
    chk("t1_stamp", 32'(rd_if.rd_stamp), 32'd0);
    repeat (3) step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("t1_drained", 32'(empty), 32'd1);

    // Compressed trace
    step(1, 1, 32'h0000_3000, 32'h1111_0000, 0, 1);
    step(1, 1, 32'h0000_3004, 32'h1111_0001, 0, 0);
    step(1, 1, 32'h0000_3008, 32'h1111_0002, 0, 0);
    step(1, 1, 32'h0000_3020, 32'h1111_0003, 0, 1);
    step(1, 1, 32'h0000_3024, 32'h1111_0004, 0, 0);
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_head",  rd_if.rd_pc, 32'h0000_3000);
    repeat (2) step(0, 1, 32'h0, 32'h0, 1, 0);
    chk("t2_empty", 32'(empty),          32'd1);
    chk("t2_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("t2_pc0",   rd_if.rd_pc,         32'd0);

    // Overflow
    for (int k = 0; k < 20; k++)
      step(1, 0, 32'h0000_4000 + 32'(k * 4), 32'h1000_0000 + 32'(k), 0, k < DEPTH);
    chk("t3_full",  32'(full),     32'd1);
    chk("t3_count", 32'(count),    32'd16);
    chk("t3_drop",  32'(drop_cnt), 32'd4);
    chk("t3_head",  rd_if.rd_pc,   32'h0000_4000);

    // Pop and write together while full
    step(1, 0, 32'h0000_5000, 32'hABCD_0000, 1, 1);
    chk("t4_count", 32'(count),    32'd16);
    chk("t4_full",  32'(full),     32'd1);
    chk("t4_drop",  32'(drop_cnt), 32'd4);
    chk("t4_head",  rd_if.rd_pc,   32'h0000_4004);
    repeat (16) step(0, 0, 32'h0, 32'h0, 1, 0);
    chk("t4_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 5; k++)
      step(1, 0, 32'h0000_6000 + 32'(k * 4), 32'h2000_0000 + 32'(k), 0, 1);
    chk("t5_count_pre", 32'(count), 32'd5);
    #2;
    PcReSet  = 1'b0;
    trace_en = 1'b0;
    sb.delete();
    #1;
    chk("t5_empty", 32'(empty),          32'd1);
    chk("t5_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("t5_count", 32'(count),          32'd0);
    chk("t5_drop",  32'(drop_cnt),       32'd0);
    chk("t5_pc",    rd_if.rd_pc,         32'd0);
    @(posedge clk);
    #1;
    PcReSet = 1'b1;
    step(1, 1, 32'h0000_0100, 32'h3000_0000, 0, 1);
    chk("t5_first", 32'(count), 32'd1);
    chk("t5_head",  rd_if.rd_pc, 32'h0000_0100);

    // PC wrap and re-enable
    step(1, 1, 32'hFFFF_FFFC, 32'h3000_0001, 0, 1);
    step(1, 1, 32'h0000_0000, 32'h3000_0002, 0, 0);
    step(0, 1, 32'h0000_0004, 32'h3000_0003, 0, 0);
    step(1, 1, 32'h0000_0008, 32'h3000_0004, 0, 1);
    chk("t6_count", 32'(count), 32'd3);
    repeat (3) step(0, 1, 32'h0, 32'h0, 1, 0);
    chk("t6_empty", 32'(empty),    32'd1);
    chk("t6_drop",  32'(drop_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
